// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one external pipelined float32
// multiplier among NREQ requesters. The winning operands are registered
// toward the multiplier. A tag pipeline, kept in step with the multiplier
// latency, carries the requester id so each result is steered back to the
// requester that issued it.
module fp_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mul_x,
  output logic [W-1:0]      mul_y,
  output logic              mul_valid,
  input  logic [W-1:0]      mul_out,
  output logic [NREQ-1:0]   resp_valid,
  output logic [W-1:0]      resp_data,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Round-robin pointer: the index searched first on the next cycle.
  logic [IW-1:0] ptr_q, ptr_d;

  // Arbitration results.
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic            grant_any;
  logic [W-1:0]    sel_x, sel_y;
  int              idx;

  // Issue register toward the multiplier, plus the id of the issued op.
  logic          mul_valid_q, mul_valid_d;
  logic [W-1:0]  mul_x_q, mul_x_d;
  logic [W-1:0]  mul_y_q, mul_y_d;
  logic [IW-1:0] mul_id_q, mul_id_d;

  // Tag pipeline. Stage 0 loads from the issue register, so the last stage
  // lines up with the cycle in which mul_out carries that op's result.
  logic [LAT-1:0]         tag_valid_q, tag_valid_d;
  logic [LAT-1:0][IW-1:0] tag_id_q, tag_id_d;

  // Result registers.
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [W-1:0]    resp_data_q, resp_data_d;

  // Search from ptr upward, wrapping, and pick the first active request.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IW'(idx);
        sel_x      = req_x[idx*W +: W];
        sel_y      = req_y[idx*W +: W];
      end
    end
  end

  // Move the pointer just past the winner; hold it when nobody transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
    end
  end

  // Register the winning operands, or zeros on an idle cycle.
  always_comb begin
    mul_valid_d = grant_any;
    mul_x_d     = grant_any ? sel_x : '0;
    mul_y_d     = grant_any ? sel_y : '0;
    mul_id_d    = grant_id;
  end

  // Shift the requester id alongside the multiplier's internal pipeline.
  always_comb begin
    tag_valid_d    = '0;
    tag_id_d       = '0;
    tag_valid_d[0] = mul_valid_q;
    tag_id_d[0]    = mul_id_q;
    for (int k = 1; k < LAT; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1];
      tag_id_d[k]    = tag_id_q[k-1];
    end
  end

  // Capture the result for the owning requester; keep the data otherwise.
  always_comb begin
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (tag_valid_q[LAT-1]) begin
      resp_valid_d[tag_id_q[LAT-1]] = 1'b1;
      resp_data_d                   = mul_out;
    end
  end

  // State update; reset discards everything that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      mul_valid_q  <= 1'b0;
      mul_x_q      <= '0;
      mul_y_q      <= '0;
      mul_id_q     <= '0;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      ptr_q        <= ptr_d;
      mul_valid_q  <= mul_valid_d;
      mul_x_q      <= mul_x_d;
      mul_y_q      <= mul_y_d;
      mul_id_q     <= mul_id_d;
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready  = grant;
  assign mul_valid  = mul_valid_q;
  assign mul_x      = mul_x_q;
  assign mul_y      = mul_y_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = mul_valid_q | (|tag_valid_q) | (|resp_valid_q);

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: directed checks of the multiplier arbiter, once with
// the default configuration (NREQ=4, LAT=3) and once with NREQ=2, LAT=1.
// A small table-driven multiplier model with the matching latency stands in
// for the external float multiplier.
module tb_fp_mult_arbiter;

  logic clk = 1'b0;
  logic reset;

  // Instance A: NREQ=4, LAT=3
  logic [3:0]   req_valid, req_ready, resp_valid;
  logic [127:0] req_x, req_y;
  logic [31:0]  mul_x, mul_y, mul_out, resp_data;
  logic         mul_valid, busy;

  // Instance B: NREQ=2, LAT=1
  logic [1:0]   b_req_valid, b_req_ready, b_resp_valid;
  logic [63:0]  b_req_x, b_req_y;
  logic [31:0]  b_mul_x, b_mul_y, b_mul_out, b_resp_data;
  logic         b_mul_valid, b_busy;

  logic [31:0]  pipe_a [3];
  logic [31:0]  pipe_b;
  logic [31:0]  exp_prod [4];

  int check_count = 0;
  int error_count = 0;

  fp_mult_arbiter #(.NREQ(4), .LAT(3), .W(32)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .mul_x(mul_x), .mul_y(mul_y), .mul_valid(mul_valid), .mul_out(mul_out),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  fp_mult_arbiter #(.NREQ(2), .LAT(1), .W(32)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_x(b_req_x), .req_y(b_req_y), .req_ready(b_req_ready),
    .mul_x(b_mul_x), .mul_y(b_mul_y), .mul_valid(b_mul_valid), .mul_out(b_mul_out),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .busy(b_busy)
  );

  always #5 clk = ~clk;

  // Exact float32 products for the operand pairs used below.
  function automatic logic [31:0] mul_model(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      64'h3F800000_3F800000: return 32'h3F800000;
      64'h3F800000_40000000: return 32'h40000000;
      64'h40000000_40400000: return 32'h40C00000;
      64'h40000000_40000000: return 32'h40800000;
      64'h40800000_3F000000: return 32'h40000000;
      64'h7FC00000_3F800000: return 32'h7FC00000;
      default:               return x ^ y;
    endcase
  endfunction

  // Multiplier model for instance A: three register stages.
  always @(posedge clk) begin
    pipe_a[0] <= mul_model(mul_x, mul_y);
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
  end
  assign mul_out = pipe_a[2];

  // Multiplier model for instance B: one register stage.
  always @(posedge clk) begin
    pipe_b <= mul_model(b_mul_x, b_mul_y);
  end
  assign b_mul_out = pipe_b;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v);
    req_valid = v;
    #1;
  endtask

  task automatic setOperands(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[i*32 +: 32] = x;
    req_y[i*32 +: 32] = y;
  endtask

  task automatic doReset();
    req_valid   = '0;
    b_req_valid = '0;
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst mul_valid", {31'd0, mul_valid}, 32'd0);
    checkOutput("rst mul_x", mul_x, 32'd0);
    checkOutput("rst resp_valid", {28'd0, resp_valid}, 32'd0);
    checkOutput("rst resp_data", resp_data, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst b_mul_valid", {31'd0, b_mul_valid}, 32'd0);
    checkOutput("rst b_resp_valid", {30'd0, b_resp_valid}, 32'd0);
    checkOutput("rst b_busy", {31'd0, b_busy}, 32'd0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_x       = '0;
    req_y       = '0;
    b_req_valid = '0;
    b_req_x     = '0;
    b_req_y     = '0;

    // Single op from requester 1: 2.0 * 3.0.
    doReset();
    setOperands(1, 32'h40000000, 32'h40400000);
    applyStimulus(4'b0010);
    checkOutput("single ready", {28'd0, req_ready}, 32'h2);
    tick();
    applyStimulus(4'b0000);
    checkOutput("single mul_valid", {31'd0, mul_valid}, 32'd1);
    checkOutput("single mul_x", mul_x, 32'h40000000);
    checkOutput("single mul_y", mul_y, 32'h40400000);
    checkOutput("single busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("single early resp", {28'd0, resp_valid}, 32'd0);
    end
    tick();
    checkOutput("single resp_valid", {28'd0, resp_valid}, 32'h2);
    checkOutput("single resp_data", resp_data, 32'h40C00000);
    tick();
    checkOutput("single resp drop", {28'd0, resp_valid}, 32'd0);
    checkOutput("single data hold", resp_data, 32'h40C00000);
    checkOutput("single idle busy", {31'd0, busy}, 32'd0);
    // Pointer now sits at 2, so with requests 0 and 1 the search wraps to 0.
    applyStimulus(4'b0011);
    checkOutput("ptr wrap ready", {28'd0, req_ready}, 32'h1);
    applyStimulus(4'b0000);

    // Full contention from reset: grants 0,1,2,3,... with matching results.
    doReset();
    setOperands(0, 32'h3F800000, 32'h40000000);
    setOperands(1, 32'h40000000, 32'h40400000);
    setOperands(2, 32'h40000000, 32'h40000000);
    setOperands(3, 32'h7FC00000, 32'h3F800000);
    exp_prod[0] = 32'h40000000;
    exp_prod[1] = 32'h40C00000;
    exp_prod[2] = 32'h40800000;
    exp_prod[3] = 32'h7FC00000;
    applyStimulus(4'b1111);
    for (int n = 0; n < 12; n++) begin
      checkOutput("rr grant", {28'd0, req_ready}, 32'(1 << (n % 4)));
      tick();
      checkOutput("rr mul_valid", {31'd0, mul_valid}, 32'd1);
      if (n >= 4) begin
        checkOutput("rr resp_valid", {28'd0, resp_valid}, 32'(1 << ((n - 4) % 4)));
        checkOutput("rr resp_data", resp_data, exp_prod[(n - 4) % 4]);
      end
    end
    applyStimulus(4'b0000);

    // Fairness: requester 0 held, requester 2 joins and alternates with it.
    doReset();
    applyStimulus(4'b0001);
    checkOutput("fair solo0 a", {28'd0, req_ready}, 32'h1);
    tick();
    checkOutput("fair solo0 b", {28'd0, req_ready}, 32'h1);
    tick();
    applyStimulus(4'b0101);
    checkOutput("fair req2 first", {28'd0, req_ready}, 32'h4);
    tick();
    checkOutput("fair back to 0", {28'd0, req_ready}, 32'h1);
    tick();
    checkOutput("fair 2 again", {28'd0, req_ready}, 32'h4);
    tick();
    checkOutput("fair 0 again", {28'd0, req_ready}, 32'h1);
    applyStimulus(4'b0000);

    // Back-to-back ops from requester 3 return in issue order.
    doReset();
    setOperands(3, 32'h3F800000, 32'h3F800000);
    applyStimulus(4'b1000);
    checkOutput("b2b ready 0", {28'd0, req_ready}, 32'h8);
    tick();
    setOperands(3, 32'h40000000, 32'h40000000);
    #1;
    checkOutput("b2b ready 1", {28'd0, req_ready}, 32'h8);
    tick();
    setOperands(3, 32'h40800000, 32'h3F000000);
    #1;
    checkOutput("b2b ready 2", {28'd0, req_ready}, 32'h8);
    tick();
    applyStimulus(4'b0000);
    tick();
    checkOutput("b2b early", {28'd0, resp_valid}, 32'd0);
    tick();
    checkOutput("b2b v0", {28'd0, resp_valid}, 32'h8);
    checkOutput("b2b d0", resp_data, 32'h3F800000);
    tick();
    checkOutput("b2b v1", {28'd0, resp_valid}, 32'h8);
    checkOutput("b2b d1", resp_data, 32'h40800000);
    tick();
    checkOutput("b2b v2", {28'd0, resp_valid}, 32'h8);
    checkOutput("b2b d2", resp_data, 32'h40000000);
    tick();
    checkOutput("b2b done", {28'd0, resp_valid}, 32'd0);

    // Reset with two ops in flight: nothing comes back afterwards.
    doReset();
    setOperands(1, 32'h40000000, 32'h40400000);
    setOperands(2, 32'h40000000, 32'h40000000);
    applyStimulus(4'b0110);
    checkOutput("mid ready 1", {28'd0, req_ready}, 32'h2);
    tick();
    checkOutput("mid ready 2", {28'd0, req_ready}, 32'h4);
    tick();
    applyStimulus(4'b0000);
    checkOutput("mid busy", {31'd0, busy}, 32'd1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("mid rst mul_valid", {31'd0, mul_valid}, 32'd0);
    checkOutput("mid rst mul_x", mul_x, 32'd0);
    checkOutput("mid rst busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput("mid no resp", {28'd0, resp_valid}, 32'd0);
      checkOutput("mid no busy", {31'd0, busy}, 32'd0);
    end
    applyStimulus(4'b1111);
    checkOutput("mid ptr restart", {28'd0, req_ready}, 32'h1);
    applyStimulus(4'b0000);

    // Instance B (NREQ=2, LAT=1): single op latency.
    doReset();
    b_req_x[0 +: 32] = 32'h40000000;
    b_req_y[0 +: 32] = 32'h40400000;
    b_req_valid = 2'b01;
    #1;
    checkOutput("b single ready", {30'd0, b_req_ready}, 32'h1);
    tick();
    b_req_valid = 2'b00;
    checkOutput("b mul_valid", {31'd0, b_mul_valid}, 32'd1);
    tick();
    checkOutput("b early", {30'd0, b_resp_valid}, 32'd0);
    tick();
    checkOutput("b resp_valid", {30'd0, b_resp_valid}, 32'h1);
    checkOutput("b resp_data", b_resp_data, 32'h40C00000);
    tick();
    checkOutput("b resp drop", {30'd0, b_resp_valid}, 32'd0);

    // Instance B contention: alternating 0,1 with matching results.
    doReset();
    b_req_x[0 +: 32]  = 32'h40000000;
    b_req_y[0 +: 32]  = 32'h40000000;
    b_req_x[32 +: 32] = 32'h3F800000;
    b_req_y[32 +: 32] = 32'h3F800000;
    exp_prod[0] = 32'h40800000;
    exp_prod[1] = 32'h3F800000;
    b_req_valid = 2'b11;
    #1;
    for (int n = 0; n < 6; n++) begin
      checkOutput("b rr grant", {30'd0, b_req_ready}, 32'(1 << (n % 2)));
      tick();
      if (n >= 2) begin
        checkOutput("b rr resp_valid", {30'd0, b_resp_valid}, 32'(1 << ((n - 2) % 2)));
        checkOutput("b rr resp_data", b_resp_data, exp_prod[(n - 2) % 2]);
      end
    end
    b_req_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
